multi_pwm_gen: RTL
==================

MULTI_PWM_GEN -- requirements
Module: multi_pwm_gen

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent PWM channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 8: width of the period counter and duty registers.
REQ-003 SHALL have parameter PERIOD, default 10: PWM period in clk cycles, 2..2^CNT_W-1.
REQ-004 SHALL have parameter STEP, default 1: duty increment/decrement per accepted button press.
REQ-005 SHALL have parameter DUTY_INIT, default 5: duty value loaded at reset, at most PERIOD.
REQ-006 SHALL have parameter DEB_DIV, default 2: debounce sample interval in clk cycles, at least 1.
REQ-007 SHALL have port clk  input  1: clock; all state on rising edge.
REQ-008 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-009 SHALL have port en  input  1: run enable for the period counter and outputs.
REQ-010 SHALL have port inc_btn  input  CHANNELS: per-channel raw increase-duty buttons, asynchronous.
REQ-011 SHALL have port dec_btn  input  CHANNELS: per-channel raw decrease-duty buttons, asynchronous.
REQ-012 SHALL have port pwm_out  output  CHANNELS: per-channel PWM outputs.
REQ-013 SHALL have port period_start  output  1: one-cycle pulse on the first cycle of each period.
REQ-014 SHALL have port duty_flat  output  CHANNELS*CNT_W: active duty per channel; channel i occupies bits [i*CNT_W +: CNT_W].

Function
REQ-015 SHALL have a shared counter cnt: with en=1 it increments each cycle, wrapping PERIOD-1 -> 0; with en=0 it is held at 0.
REQ-016 SHALL drive period_start=1 in exactly the cycles where en=1 and cnt==0.
REQ-017 SHALL implement a divider that asserts tick for one cycle every DEB_DIV cycles (every cycle when DEB_DIV=1), free-running regardless of en.
REQ-018 SHALL, per channel and per button on tick, shift the button through a 2-FF sampler (s1<=btn, s2<=s1); press event = s1 & ~s2 & tick.
REQ-019 SHALL, on an inc event, set the channel's shadow duty to min(shadow+STEP, PERIOD), and on a dec event to max(shadow-STEP, 0); the computation SHALL use CNT_W+1 bits so it never wraps.
REQ-020 SHALL leave shadow duty unchanged when inc and dec events for the same channel coincide.
REQ-021 SHALL copy shadow to active duty for all channels together in the cycle cnt wraps PERIOD-1 -> 0 (glitch-free update); while en=0, active SHALL track shadow every cycle.
REQ-022 SHALL drive pwm_out[i] = en & (cnt < active[i]) combinationally from registers; active=0 gives constant low, active=PERIOD gives constant high.
REQ-023 SHALL make duty_flat reflect the active registers, not the shadow registers.

Reset
REQ-024 SHALL, while reset=1, force cnt, divider, and all samplers to 0 and set shadow and active duty to DUTY_INIT for every channel.
REQ-025 SHALL produce pwm_out=0 and period_start=0 during reset; reset asserted mid-period SHALL abort the period immediately, with no pending press retained.
REQ-026 SHALL, after reset deassertion with en=1, treat the first cycle as cnt=0 with period_start=1.

Configuration
REQ-027 SHALL support macro PWM_CENTER_ALIGNED_EN; when defined, cnt counts 0..PERIOD-1 then PERIOD-1..0 (period 2*PERIOD cycles, each endpoint held twice).
REQ-028 With PWM_CENTER_ALIGNED_EN defined, the copy from shadow to active and period_start SHALL occur only at the down-to-up turn at cnt==0, and pwm_out SHALL keep the rule of REQ-022.
REQ-029 Without PWM_CENTER_ALIGNED_EN, the block SHALL be edge-aligned as in REQ-015 and SHALL contain no direction register.

Verification (defaults unless stated)
REQ-030 SHALL cover reset, then en=1 -> pwm_out[0] high for 5 of every 10 cycles; period_start every 10 cycles.
REQ-031 SHALL cover an inc_btn[1] pulse held for 8 cycles -> exactly one accepted event; duty_flat ch1 becomes 6 only at the next wrap; pwm_out[1] is high for 6 of 10 cycles.
REQ-032 SHALL cover 7 separate inc presses on ch2 -> duty saturates at 10 and pwm_out[2] stays constant high; 12 dec presses -> 0 and constant low, with no wrap.
REQ-033 SHALL cover simultaneous inc and dec presses on ch3 -> duty stays 5; ch0 is unaffected by ch3 presses.
REQ-034 SHALL cover reset asserted at cnt=7 -> outputs are 0 immediately, and all duties are 5 after release.
REQ-035 SHALL cover PWM_CENTER_ALIGNED_EN with duty 5 -> a 20-cycle period, pwm_out high for 10 cycles centered on cnt==0.

Source files
------------

// File: rtl/multi_pwm_gen.sv
// Multi-channel PWM generator with debounced per-channel duty buttons and a shared period counter.
// Optional PWM_CENTER_ALIGNED_EN selects an up/down (center-aligned) counter; default is edge-aligned.
module multi_pwm_gen #(
    parameter int CHANNELS  = 4,
    parameter int CNT_W     = 8,
    parameter int PERIOD    = 10,
    parameter int STEP      = 1,
    parameter int DUTY_INIT = 5,
    parameter int DEB_DIV   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [CHANNELS-1:0]       inc_btn,
    input  logic [CHANNELS-1:0]       dec_btn,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_start,
    output logic [CHANNELS*CNT_W-1:0] duty_flat
);

    localparam int                DIV_W    = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  INIT     = CNT_W'(DUTY_INIT);
    localparam logic [CNT_W:0]    PER_X    = (CNT_W+1)'(PERIOD);
    localparam logic [CNT_W:0]    STEP_X   = (CNT_W+1)'(STEP);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DEB_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);

    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [DIV_W-1:0]                div_q, div_d;
    logic [CHANNELS-1:0]             inc_s1_q, inc_s1_d, inc_s2_q, inc_s2_d;
    logic [CHANNELS-1:0]             dec_s1_q, dec_s1_d, dec_s2_q, dec_s2_d;
    logic [CHANNELS-1:0][CNT_W-1:0]  shadow_q, shadow_d, active_q, active_d;
    logic                            tick_s, wrap_s, start_s;
    logic [CHANNELS-1:0]             inc_ev_s, dec_ev_s;
`ifdef PWM_CENTER_ALIGNED_EN
    logic                            dir_q, dir_d;   // 1 = counting up

    // Up/down counter; wrap_s marks the down-to-up turn at zero, where a new period begins.
    always_comb begin
        cnt_d  = CNT_ZERO;
        dir_d  = 1'b1;
        wrap_s = 1'b0;
        if (en) begin
            cnt_d = cnt_q;
            dir_d = dir_q;
            if (dir_q) begin
                if (cnt_q == CNT_LAST) begin
                    dir_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                if (cnt_q == CNT_ZERO) begin
                    dir_d  = 1'b1;
                    wrap_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
        end else begin
            cnt_d = CNT_ZERO;
        end
    end

    assign start_s = (cnt_q == CNT_ZERO) && dir_q;
`else
    // Edge-aligned counter 0..PERIOD-1; held at zero while disabled.
    always_comb begin
        cnt_d  = CNT_ZERO;
        wrap_s = 1'b0;
        if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = CNT_ZERO;
                wrap_s = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = CNT_ZERO;
        end
    end

    assign start_s = (cnt_q == CNT_ZERO);
`endif

    assign tick_s   = (div_q == DIV_LAST);
    assign inc_ev_s = inc_s1_q & ~inc_s2_q & {CHANNELS{tick_s}};
    assign dec_ev_s = dec_s1_q & ~dec_s2_q & {CHANNELS{tick_s}};

    // Free-running debounce divider and 2-FF button samplers advanced only on tick.
    always_comb begin
        div_d    = tick_s ? {DIV_W{1'b0}} : div_q + DIV_ONE;
        inc_s1_d = inc_s1_q;
        inc_s2_d = inc_s2_q;
        dec_s1_d = dec_s1_q;
        dec_s2_d = dec_s2_q;
        if (tick_s) begin
            inc_s1_d = inc_btn;
            inc_s2_d = inc_s1_q;
            dec_s1_d = dec_btn;
            dec_s2_d = dec_s1_q;
        end else begin
            inc_s1_d = inc_s1_q;
            dec_s1_d = dec_s1_q;
        end
    end

    // Saturating duty update in CNT_W+1 bits; the active copy follows shadow at wrap or while disabled.
    always_comb begin
        logic [CNT_W:0] up_x;
        logic [CNT_W:0] dn_x;
        shadow_d = shadow_q;
        up_x     = {(CNT_W+1){1'b0}};
        dn_x     = {(CNT_W+1){1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            up_x = {1'b0, shadow_q[i]} + STEP_X;
            if (up_x > PER_X) begin
                up_x = PER_X;
            end else begin
                up_x = up_x;
            end
            if ({1'b0, shadow_q[i]} < STEP_X) begin
                dn_x = {(CNT_W+1){1'b0}};
            end else begin
                dn_x = {1'b0, shadow_q[i]} - STEP_X;
            end
            if (inc_ev_s[i] && !dec_ev_s[i]) begin
                shadow_d[i] = up_x[CNT_W-1:0];
            end else if (dec_ev_s[i] && !inc_ev_s[i]) begin
                shadow_d[i] = dn_x[CNT_W-1:0];
            end else begin
                shadow_d[i] = shadow_q[i];
            end
        end
        active_d = (!en || wrap_s) ? shadow_q : active_q;
    end

    // State registers; reset aborts the period and drops any half-sampled press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= CNT_ZERO;
            div_q    <= {DIV_W{1'b0}};
            inc_s1_q <= {CHANNELS{1'b0}};
            inc_s2_q <= {CHANNELS{1'b0}};
            dec_s1_q <= {CHANNELS{1'b0}};
            dec_s2_q <= {CHANNELS{1'b0}};
            shadow_q <= {CHANNELS{INIT}};
            active_q <= {CHANNELS{INIT}};
`ifdef PWM_CENTER_ALIGNED_EN
            dir_q    <= 1'b1;
`endif
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            inc_s1_q <= inc_s1_d;
            inc_s2_q <= inc_s2_d;
            dec_s1_q <= dec_s1_d;
            dec_s2_q <= dec_s2_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
`ifdef PWM_CENTER_ALIGNED_EN
            dir_q    <= dir_d;
`endif
        end
    end

    // Outputs decode registered state; reset gating forces them low immediately.
    always_comb begin
        pwm_out = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_out[i] = en && !reset && (cnt_q < active_q[i]);
        end
        period_start = en && !reset && start_s;
    end

    assign duty_flat = active_q;

endmodule
